// File: rtl/systolic_input_skewer_pkg.sv
// Shared accelerator definitions: matrix-unit geometry defaults and skewer FSM encoding.
package systolic_input_skewer_pkg;

    localparam int unsigned MmuWidth  = 8;
    localparam int unsigned MmuLength = 10;

    typedef logic [1:0] skewer_state_t;

    localparam skewer_state_t StIdle   = 2'd0;
    localparam skewer_state_t StStream = 2'd1;
    localparam skewer_state_t StFlush  = 2'd2;
    localparam skewer_state_t StDone   = 2'd3;

endpackage

// File: rtl/systolic_input_skewer_skew_delay_line.sv
// One skew lane: a DEPTH-stage shift chain that moves only when shift is high.
module skew_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             CLK,
    input  logic             ASYNC_RST,
    input  logic             SYNC_RST,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d, shifted;

    // Stage 0 takes din; the oldest sample sits in stage DEPTH-1.
    if (DEPTH > 1) begin : g_chain
        assign shifted = {stage_q[DEPTH-2:0], din};
    end else begin : g_single
        assign shifted = din;
    end

    always_comb begin
        stage_d = stage_q;
        if (shift) begin
            stage_d = shifted;
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            stage_q <= '0;
        end else if (SYNC_RST) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Turns one activation column per handshake into the diagonal wavefront the systolic array
// consumes, with a matching array enable and a per-tile completion pulse.
module systolic_input_skewer
    import systolic_input_skewer_pkg::*;
#(
    parameter int unsigned WIDTH  = MmuWidth,
    parameter int unsigned LENGTH = MmuLength
) (
    input  logic                          CLK,
    input  logic                          ASYNC_RST,
    input  logic                          SYNC_RST,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic [0:LENGTH-1][WIDTH-1:0]  In_Vector,
    output logic [0:LENGTH-1][WIDTH-1:0]  Inputs,
    output logic                          MMU_EN,
    output logic                          Busy,
    output logic                          Tile_Done
);

    localparam int unsigned CntW = $clog2(LENGTH + 1);
    localparam logic [CntW-1:0] LastVec   = CntW'(LENGTH - 1);
    localparam logic [CntW-1:0] LastFlush = CntW'((LENGTH > 1) ? (LENGTH - 2) : 0);

    skewer_state_t   state_q, state_d;
    logic [CntW-1:0] vec_cnt_q, vec_cnt_d;
    logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
    logic            mmu_en_q, mmu_en_d;
    logic            accept;
    logic            advance;

    // Ready is withheld while either reset is asserted so no column is taken during a clear.
    assign In_Ready = ASYNC_RST & ~SYNC_RST &
                      ((state_q == StIdle) | (state_q == StStream));
    assign accept   = In_Valid & In_Ready;
    assign advance  = accept | (state_q == StFlush);

    always_comb begin
        state_d     = state_q;
        vec_cnt_d   = vec_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mmu_en_d    = advance;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    vec_cnt_d = CntW'(1);
                    state_d   = (LENGTH == 1) ? StDone : StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    vec_cnt_d = vec_cnt_q + CntW'(1);
                    if (vec_cnt_q == LastVec) begin
                        state_d     = StFlush;
                        flush_cnt_d = '0;
                    end
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q + CntW'(1);
                if (flush_cnt_q == LastFlush) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d     = StIdle;
                vec_cnt_d   = '0;
                flush_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q     <= StIdle;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
            mmu_en_q    <= 1'b0;
        end else if (SYNC_RST) begin
            state_q     <= StIdle;
            vec_cnt_q   <= '0;
            flush_cnt_q <= '0;
            mmu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_cnt_q   <= vec_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mmu_en_q    <= mmu_en_d;
        end
    end

    // Lane r is r+1 deep so row r lags row 0 by r advance steps; flush feeds zeros.
    for (genvar r = 0; r < LENGTH; r++) begin : g_lane
        logic [WIDTH-1:0] lane_din;

        assign lane_din = accept ? In_Vector[r] : '0;

        skew_delay_line #(
            .WIDTH (WIDTH),
            .DEPTH (r + 1)
        ) u_line (
            .CLK       (CLK),
            .ASYNC_RST (ASYNC_RST),
            .SYNC_RST  (SYNC_RST),
            .shift     (advance),
            .din       (lane_din),
            .dout      (Inputs[r])
        );
    end

    assign MMU_EN    = mmu_en_q;
    assign Busy      = (state_q != StIdle);
    assign Tile_Done = (state_q == StDone);

endmodule

// File: doc/systolic_input_skewer.md
Name: systolic_input_skewer

Overview:
- Sits directly upstream of the matrix multiply unit and drives its Inputs bus.
- Accepts one column vector of the activation matrix per handshake, element r = A[r][k].
- Emits the diagonal-skewed wavefront the systolic array needs: row r delayed r steps, zero-filled.
- Generates the array enable so the array advances only when new skewed data is presented, then signals completion of each tile.

Parameters:
- WIDTH, 8, bits per activation element.
- LENGTH, 10, array dimension (rows per vector, vectors per tile); legal range >= 1.

Ports:
- CLK  in  1  clock, all state on rising edge.
- ASYNC_RST  in  1  asynchronous active-low reset.
- SYNC_RST  in  1  synchronous active-high clear, same effect as ASYNC_RST.
- In_Valid  in  1  In_Vector holds a valid column.
- In_Ready  out  1  skewer can accept a column this cycle.
- In_Vector  in  WIDTH x [0:LENGTH-1]  column k of A, element r = A[r][k].
- Inputs  out  WIDTH x [0:LENGTH-1]  skewed data to the matrix multiply unit, registered.
- MMU_EN  out  1  registered; high for exactly the cycles in which Inputs carries a new wavefront step.
- Busy  out  1  state != IDLE.
- Tile_Done  out  1  one-cycle pulse coincident with the last MMU_EN of a tile.

Behaviour:
- Reset (either source): state IDLE, counters 0, all skew registers 0, Inputs all 0, MMU_EN 0, Tile_Done 0, In_Ready 0 during reset then 1 once in IDLE.
- Internal signal advance = (accept) | (state == FLUSH), where accept = In_Valid & In_Ready.
- Skew structure: lane r is a shift chain of r+1 registers. Its last stage drives Inputs[r]. The chain shifts only on advance.
  - accept: lane r shifts in In_Vector[r].
  - FLUSH: lane r shifts in 0.
  - No advance: all chains hold.
- Timing: element r of the vector accepted on advance step k appears on Inputs[r] after the edge of advance step k+r.
- MMU_EN <= advance, so MMU_EN is high exactly one cycle after each advance edge.
- The unit produces exactly 2*LENGTH-1 MMU_EN steps per tile.
- With contiguous In_Valid, step s presents Inputs[r] = A[r][s-r] when 0 <= s-r < LENGTH, else 0.
- FSM:
  - IDLE: In_Ready = 1. On accept: vec_cnt <= 1. If LENGTH == 1, go to DONE; else go to STREAM.
  - STREAM: In_Ready = 1. Each accept increments vec_cnt. If In_Valid is low, nothing shifts and MMU_EN is 0, so the array freezes and the wavefront stays aligned. When the accept has vec_cnt == LENGTH-1, go to FLUSH with flush_cnt <= 0.
  - FLUSH: In_Ready = 0. Advances every cycle and increments flush_cnt. After LENGTH-1 flush advances, go to DONE.
  - DONE: one cycle; Tile_Done = 1 aligned with the final MMU_EN; In_Ready = 0; then return to IDLE.
- Counter widths: $clog2(LENGTH+1) bits. No wrap is possible because the counters are bounded by the FSM.
- Next tile: a new tile can begin on the cycle after DONE. Its first accept reuses the zero-flushed chains.
- In_Vector is sampled only on accept; its value is don't-care otherwise.
- Reset mid-tile: the partial tile is discarded, chains are zeroed, the FSM returns to IDLE, and no Tile_Done is issued.
- SYNC_RST has priority over all other synchronous activity in that cycle.

Decomposition:
- Shared package (accelerator-wide): skewer state enum (IDLE, STREAM, FLUSH, DONE). WIDTH/LENGTH defaults are shared with the matrix multiply unit.
- One natural sub-module: skew_delay_line (parameters WIDTH, DEPTH; ports CLK, ASYNC_RST, SYNC_RST, shift, din, dout), instantiated per lane with DEPTH = r+1 via a generate loop.
- The FSM and counters stay in the top level.

Test Plan:
- Reset: hold ASYNC_RST = 0 for 2 cycles, then release -> Inputs all 0, MMU_EN = 0, Busy = 0, In_Ready = 1.
- LENGTH = 4, contiguous vectors A[r][k] = 10*r + k -> MMU_EN high 7 consecutive cycles:
  - step 0: Inputs = {0,0,0,0}
  - step 3: Inputs = {3,12,21,30}
  - step 6: Inputs = {0,0,0,33}
  - Tile_Done high with step 6.
- Same matrix with In_Valid low for 3 cycles after the 2nd vector -> MMU_EN low for those 3 cycles, Inputs held, and the step sequence is identical to the contiguous case.
- In FLUSH, drive In_Valid = 1 -> In_Ready = 0, no accept, and vec_cnt/chains are unaffected by In_Vector.
- Assert ASYNC_RST at step 4 of a tile -> Inputs immediately 0, no Tile_Done. A following full tile with identity-like data ({1,0,0,0} etc.) reproduces the correct skew.
- End-to-end: connect to the matrix multiply unit (LENGTH = 10) with preloaded weights and random 0..10 matrices -> collected results equal W*A for 3 back-to-back tiles.
